// File: rtl/udp_link_monitor.sv
// udp_link_monitor
// Parses "FO"+command UDP payloads from the RX demux, tracks the user-link
// state and the connected host, and drops the link after a keep-alive timeout.
module udp_link_monitor #(
  parameter int CLK_FREQ_MHZ     = 100,
  parameter int LINK_TIMEOUT_SEC = 5,
  // Tier sizes of the timeout chain (us per ms, ms per s); 1000 for real time.
  parameter int US_PER_MS        = 1000,
  parameter int MS_PER_SEC       = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_sof,
  input  logic        i_rx_eof,
  input  logic [31:0] i_rx_src_ip,
  input  logic [15:0] i_rx_src_port,
  output logic        o_userlink_state,
  output logic [31:0] o_host_ip,
  output logic [15:0] o_host_port,
  output logic        o_disc_req,
  output logic        o_link_lost
);

  localparam logic [7:0] MAGIC0     = 8'h46;
  localparam logic [7:0] MAGIC1     = 8'h4F;
  localparam logic [7:0] CMD_DISC   = 8'h01;
  localparam logic [7:0] CMD_CONN   = 8'h02;
  localparam logic [7:0] CMD_DCONN  = 8'h03;
  localparam logic [7:0] PRESC_LAST = 8'(CLK_FREQ_MHZ - 1);
  localparam logic [9:0] US_LAST    = 10'(US_PER_MS - 1);
  localparam logic [9:0] MS_LAST    = 10'(MS_PER_SEC - 1);
  localparam logic [7:0] SEC_LAST   = 8'(LINK_TIMEOUT_SEC - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_MAG1, ST_CMD, ST_WAIT, ST_DROP
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cmd_reg;
  logic [31:0] src_ip_reg;
  logic [15:0] src_port_reg;
  logic        commit;
  logic [7:0]  commit_cmd;

  logic        link_reg;
  logic [31:0] host_ip_reg;
  logic [15:0] host_port_reg;
  logic        disc_reg;
  logic        lost_reg;

  logic [7:0]  presc_reg;
  logic [9:0]  us_reg;
  logic [9:0]  ms_reg;
  logic [7:0]  sec_reg;

  logic host_match, is_disc, is_connect, is_disconnect, is_keepalive, refresh;
  logic tick_us, tick_ms, tick_sec, expire;

  // Parser state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Parser next state; a sof beat always restarts parsing from that byte
  always_comb begin
    state_next = state_reg;
    if (i_rx_valid) begin
      if (i_rx_sof) begin
        if (i_rx_eof)                state_next = ST_IDLE;
        else if (i_rx_data == MAGIC0) state_next = ST_MAG1;
        else                          state_next = ST_DROP;
      end else begin
        case (state_reg)
          ST_IDLE: state_next = ST_IDLE;
          ST_MAG1: begin
            if (i_rx_eof)                 state_next = ST_IDLE;
            else if (i_rx_data == MAGIC1) state_next = ST_CMD;
            else                          state_next = ST_DROP;
          end
          ST_CMD:  state_next = i_rx_eof ? ST_IDLE : ST_WAIT;
          ST_WAIT: if (i_rx_eof) state_next = ST_IDLE;
          ST_DROP: if (i_rx_eof) state_next = ST_IDLE;
          default: state_next = ST_IDLE;
        endcase
      end
    end
  end

  // Parser outputs: commit on a non-sof eof in CMD (command is this byte) or WAIT
  always_comb begin
    commit     = 1'b0;
    commit_cmd = cmd_reg;
    if (i_rx_valid && !i_rx_sof && i_rx_eof) begin
      if (state_reg == ST_CMD) begin
        commit     = 1'b1;
        commit_cmd = i_rx_data;
      end else if (state_reg == ST_WAIT) begin
        commit = 1'b1;
      end
    end
  end

  // Capture the frame source at sof and the command byte in CMD
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmd_reg      <= '0;
      src_ip_reg   <= '0;
      src_port_reg <= '0;
    end else if (i_rx_valid) begin
      if (i_rx_sof) begin
        src_ip_reg   <= i_rx_src_ip;
        src_port_reg <= i_rx_src_port;
      end else if (state_reg == ST_CMD) begin
        cmd_reg <= i_rx_data;
      end
    end
  end

  assign host_match    = (src_ip_reg == host_ip_reg) && (src_port_reg == host_port_reg);
  assign is_disc       = commit && (commit_cmd == CMD_DISC);
  assign is_connect    = commit && (commit_cmd == CMD_CONN);
  assign is_disconnect = commit && (commit_cmd == CMD_DCONN) && link_reg && host_match;
  assign is_keepalive  = commit && (commit_cmd != CMD_DISC) && (commit_cmd != CMD_CONN) &&
                         (commit_cmd != CMD_DCONN) && link_reg && host_match;
  assign refresh       = is_connect || is_disconnect || is_keepalive;

  assign tick_us  = link_reg && (presc_reg == PRESC_LAST);
  assign tick_ms  = tick_us && (us_reg == US_LAST);
  assign tick_sec = tick_ms && (ms_reg == MS_LAST);
  assign expire   = tick_sec && (sec_reg == SEC_LAST);

  // Timeout chain: runs only while linked, cleared by any refresh or expiry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_reg <= '0;
      us_reg    <= '0;
      ms_reg    <= '0;
      sec_reg   <= '0;
    end else if (!link_reg || refresh || expire) begin
      presc_reg <= '0;
      us_reg    <= '0;
      ms_reg    <= '0;
      sec_reg   <= '0;
    end else begin
      presc_reg <= tick_us ? 8'd0 : presc_reg + 8'd1;
      if (tick_ms)      us_reg <= '0;
      else if (tick_us) us_reg <= us_reg + 10'd1;
      if (tick_sec)     ms_reg <= '0;
      else if (tick_ms) ms_reg <= ms_reg + 10'd1;
      if (tick_sec)     sec_reg <= sec_reg + 8'd1;
    end
  end

  // Link state and host registers; a refresh takes priority over expiry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      link_reg      <= 1'b0;
      host_ip_reg   <= '0;
      host_port_reg <= '0;
      disc_reg      <= 1'b0;
      lost_reg      <= 1'b0;
    end else begin
      disc_reg <= is_disc;
      lost_reg <= 1'b0;
      if (is_connect) begin
        link_reg      <= 1'b1;
        host_ip_reg   <= src_ip_reg;
        host_port_reg <= src_port_reg;
      end else if (is_disconnect) begin
        link_reg <= 1'b0;
      end else if (!is_keepalive && expire) begin
        link_reg <= 1'b0;
        lost_reg <= 1'b1;
      end
    end
  end

  assign o_userlink_state = link_reg;
  assign o_host_ip        = host_ip_reg;
  assign o_host_port      = host_port_reg;
  assign o_disc_req       = disc_reg;
  assign o_link_lost      = lost_reg;

endmodule

// File: tb/tb_udp_link_monitor.sv
// tb_udp_link_monitor
// Directed frames against a frame-level reference model compared every cycle,
// plus hand-computed literal expectations at key points.
`timescale 1ns/1ps
module tb_udp_link_monitor;
  localparam int CLK_FREQ_MHZ     = 2;
  localparam int LINK_TIMEOUT_SEC = 2;
  localparam int US_PER_MS        = 5;
  localparam int MS_PER_SEC       = 4;
  // 2 s * 4 ms/s * 5 us/ms * 2 cycles/us
  localparam int TIMEOUT_CYCLES   = 80;
  localparam logic [31:0] HOST_IP    = 32'hC0A8010A;
  localparam logic [15:0] HOST_PORT  = 16'h1388;
  localparam logic [31:0] OTHER_IP   = 32'hC0A80114;
  localparam logic [15:0] OTHER_PORT = 16'h2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid, rx_sof, rx_eof;
  logic [7:0]  rx_data;
  logic [31:0] rx_src_ip;
  logic [15:0] rx_src_port;
  logic        userlink_state, disc_req, link_lost;
  logic [31:0] host_ip;
  logic [15:0] host_port;

  int checks = 0;
  int errors = 0;

  udp_link_monitor #(
    .CLK_FREQ_MHZ(CLK_FREQ_MHZ), .LINK_TIMEOUT_SEC(LINK_TIMEOUT_SEC),
    .US_PER_MS(US_PER_MS), .MS_PER_SEC(MS_PER_SEC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rx_valid(rx_valid), .i_rx_data(rx_data), .i_rx_sof(rx_sof), .i_rx_eof(rx_eof),
    .i_rx_src_ip(rx_src_ip), .i_rx_src_port(rx_src_port),
    .o_userlink_state(userlink_state), .o_host_ip(host_ip), .o_host_port(host_port),
    .o_disc_req(disc_req), .o_link_lost(link_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: collects each frame's bytes, decides at eof, and
  // counts idle cycles since the last refresh.
  logic        m_link, m_disc, m_lost, m_in_frame;
  logic [31:0] m_ip, m_fip;
  logic [15:0] m_port, m_fport;
  int          m_idle;
  logic [7:0]  m_bytes[$];

  always @(posedge clk or negedge rst_n) begin
    logic       have_cmd, refreshed, match;
    logic [7:0] cmd;
    if (!rst_n) begin
      m_link = 0; m_ip = 0; m_port = 0; m_disc = 0; m_lost = 0;
      m_in_frame = 0; m_idle = 0; m_fip = 0; m_fport = 0;
      m_bytes.delete();
    end else begin
      have_cmd = 0; refreshed = 0; cmd = 0;
      m_disc = 0; m_lost = 0;
      if (rx_valid) begin
        if (rx_sof) begin
          m_bytes.delete();
          m_in_frame = 1;
          m_fip = rx_src_ip;
          m_fport = rx_src_port;
        end
        if (m_in_frame) m_bytes.push_back(rx_data);
        if (rx_eof) begin
          if (m_in_frame && m_bytes.size() >= 3 && m_bytes[0] == 8'h46 && m_bytes[1] == 8'h4F) begin
            have_cmd = 1;
            cmd = m_bytes[2];
          end
          m_in_frame = 0;
          m_bytes.delete();
        end
      end
      if (have_cmd) begin
        match = m_link && (m_fip == m_ip) && (m_fport == m_port);
        case (cmd)
          8'h01: m_disc = 1;
          8'h02: begin m_link = 1; m_ip = m_fip; m_port = m_fport; refreshed = 1; end
          8'h03: if (match) begin m_link = 0; refreshed = 1; end
          default: if (match) refreshed = 1;
        endcase
      end
      if (refreshed || !m_link) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TIMEOUT_CYCLES) begin
          m_link = 0; m_lost = 1; m_idle = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("userlink_state", 32'(userlink_state), 32'(m_link));
      check("host_ip", host_ip, m_ip);
      check("host_port", 32'(host_port), 32'(m_port));
      check("disc_req", 32'(disc_req), 32'(m_disc));
      check("link_lost", 32'(link_lost), 32'(m_lost));
    end
  end

  task automatic drive_beat(input logic [7:0] d, input logic sof, input logic eof,
                            input logic [31:0] ip, input logic [15:0] port);
    @(negedge clk);
    rx_valid = 1; rx_data = d; rx_sof = sof; rx_eof = eof;
    rx_src_ip = ip; rx_src_port = port;
  endtask

  task automatic end_frame();
    @(negedge clk);
    rx_valid = 0; rx_sof = 0; rx_eof = 0; rx_data = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends n bytes (b0, b1, b2, then 0xAA filler) and returns just after the eof edge
  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int n, input logic [31:0] ip, input logic [15:0] port);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? b0 : (i == 1) ? b1 : (i == 2) ? b2 : 8'hAA;
      drive_beat(d, i == 0, i == n - 1, ip, port);
    end
    end_frame();
  endtask

  // Counts cycles from now until the link falls; bounded
  task automatic wait_drop(input longint t0, output int cycles);
    int guard = 0;
    while (userlink_state && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    cycles = int'(($time - t0) / 10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0;
    int     cyc;
    rst_n = 0; rx_valid = 0; rx_sof = 0; rx_eof = 0; rx_data = 0;
    rx_src_ip = 0; rx_src_port = 0;
    idle(3);
    rst_n = 1;
    @(negedge clk);
    check("reset_link", 32'(userlink_state), 32'd0);
    check("reset_ip", host_ip, 32'd0);
    check("reset_port", 32'(host_port), 32'd0);
    check("reset_disc", 32'(disc_req), 32'd0);
    check("reset_lost", 32'(link_lost), 32'd0);
    $display("reset released, outputs idle");

    // Discovery: pulse at eof+1 only, no link change
    send_frame(8'h46, 8'h4F, 8'h01, 3, HOST_IP, HOST_PORT);
    check("t1_disc_pulse", 32'(disc_req), 32'd1);
    check("t1_link", 32'(userlink_state), 32'd0);
    check("t1_ip", host_ip, 32'd0);
    @(negedge clk);
    check("t1_disc_one_cycle", 32'(disc_req), 32'd0);
    $display("discover 46 4F 01 sent");
    // Discovery with trailing bytes commits at the later eof
    send_frame(8'h46, 8'h4F, 8'h01, 5, HOST_IP, HOST_PORT);
    check("t1_disc_long", 32'(disc_req), 32'd1);
    $display("discover 46 4F 01 AA AA sent");

    // Connect
    send_frame(8'h46, 8'h4F, 8'h02, 3, HOST_IP, HOST_PORT);
    t0 = $time;
    check("t2_link", 32'(userlink_state), 32'd1);
    check("t2_ip", host_ip, 32'hC0A8010A);
    check("t2_port", 32'(host_port), 32'h1388);
    $display("connect from %h:%h", HOST_IP, HOST_PORT);

    // Timeout with no traffic
    wait_drop(t0, cyc);
    check("t3_timeout_cycles", 32'(cyc), 32'd80);
    check("t3_lost_pulse", 32'(link_lost), 32'd1);
    check("t3_ip_kept", host_ip, 32'hC0A8010A);
    $display("link dropped after %0d cycles", cyc);

    // Keep-alives from the host hold the link up
    send_frame(8'h46, 8'h4F, 8'h02, 3, HOST_IP, HOST_PORT);
    for (int i = 0; i < 4; i++) begin
      idle(56);
      send_frame(8'h46, 8'h4F, 8'h10, 3, HOST_IP, HOST_PORT);
      $display("keep-alive %0d from host", i);
    end
    t0 = $time;
    check("t4_link_held", 32'(userlink_state), 32'd1);
    // Same frame from another source is not a refresh
    idle(30);
    send_frame(8'h46, 8'h4F, 8'h10, 3, OTHER_IP, HOST_PORT);
    $display("keep-alive from foreign ip");
    wait_drop(t0, cyc);
    check("t4_foreign_no_refresh", 32'(cyc), 32'd80);
    $display("link dropped after %0d cycles", cyc);

    // Malformed frames
    send_frame(8'h46, 8'h4F, 8'h00, 2, HOST_IP, HOST_PORT);
    send_frame(8'h46, 8'h00, 8'h02, 3, HOST_IP, HOST_PORT);
    check("t5_no_commit", 32'(userlink_state), 32'd0);
    $display("short and bad-magic frames sent");
    // Restart mid-frame: only the second frame (from OTHER) counts
    drive_beat(8'h46, 1'b1, 1'b0, HOST_IP, HOST_PORT);
    drive_beat(8'h4F, 1'b0, 1'b0, HOST_IP, HOST_PORT);
    drive_beat(8'h46, 1'b1, 1'b0, OTHER_IP, OTHER_PORT);
    drive_beat(8'h4F, 1'b0, 1'b0, OTHER_IP, OTHER_PORT);
    drive_beat(8'h02, 1'b0, 1'b1, OTHER_IP, OTHER_PORT);
    end_frame();
    check("t5_restart_link", 32'(userlink_state), 32'd1);
    check("t5_restart_ip", host_ip, 32'hC0A80114);
    check("t5_restart_port", 32'(host_port), 32'h2000);
    $display("restarted connect from %h:%h", OTHER_IP, OTHER_PORT);

    // Disconnect from a non-host is ignored, from the host drops silently
    send_frame(8'h46, 8'h4F, 8'h03, 3, HOST_IP, HOST_PORT);
    check("t6_foreign_disconnect", 32'(userlink_state), 32'd1);
    send_frame(8'h46, 8'h4F, 8'h03, 3, OTHER_IP, OTHER_PORT);
    check("t6_disconnect_link", 32'(userlink_state), 32'd0);
    check("t6_disconnect_no_lost", 32'(link_lost), 32'd0);
    $display("disconnect from host");

    // Reset mid-frame
    send_frame(8'h46, 8'h4F, 8'h02, 3, HOST_IP, HOST_PORT);
    drive_beat(8'h46, 1'b1, 1'b0, HOST_IP, HOST_PORT);
    #2 rst_n = 0;
    #1;
    check("t6_rst_link", 32'(userlink_state), 32'd0);
    check("t6_rst_ip", host_ip, 32'd0);
    check("t6_rst_port", 32'(host_port), 32'd0);
    check("t6_rst_lost", 32'(link_lost), 32'd0);
    end_frame();
    idle(1);
    rst_n = 1;
    // Continuation bytes after reset must not commit
    drive_beat(8'h4F, 1'b0, 1'b0, HOST_IP, HOST_PORT);
    drive_beat(8'h02, 1'b0, 1'b1, HOST_IP, HOST_PORT);
    end_frame();
    check("t6_no_commit_after_rst", 32'(userlink_state), 32'd0);
    $display("reset mid-frame");

    idle(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
